// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// It moves a data payload and a control payload through DEPTH chained stages,
// with one valid bit per stage. The hazard unit and the debug unit control it
// through step gating, stall (hold) and flush (bubble insertion). Two
// saturating event counters record effective stalls and flushes.
// All state changes on the falling clock edge.

module pipe_stage_reg #(
   parameter int NB_DATA = 32,
   parameter int NB_CTRL = 16,
   parameter int DEPTH   = 1,
   parameter int NB_CNT  = 16
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_step,
   input  logic                         i_stall,
   input  logic                         i_flush,
   input  logic                         i_valid,
   input  logic [NB_DATA-1:0]           i_data,
   input  logic [NB_CTRL-1:0]           i_ctrl,
   input  logic                         i_clr_cnt,
   output logic                         o_valid,
   output logic [NB_DATA-1:0]           o_data,
   output logic [NB_CTRL-1:0]           o_ctrl,
   output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
   output logic [NB_CNT-1:0]            o_stall_cnt,
   output logic [NB_CNT-1:0]            o_flush_cnt
);

   localparam int NB_OCC = $clog2(DEPTH+1);
   localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

   // Chains longer than four stages (or empty chains) are not supported.
   generate
      if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
         $error("pipe_stage_reg: DEPTH must be in 1..4");
      end
   endgenerate

   // Per-stage state. Index 0 is next to the input; DEPTH-1 drives the outputs.
   logic [DEPTH-1:0]   r_valid;
   logic [NB_DATA-1:0] r_data [DEPTH];
   logic [NB_CTRL-1:0] r_ctrl [DEPTH];
   logic [NB_OCC-1:0]  r_occupancy;
   logic [NB_CNT-1:0]  r_stall_cnt;
   logic [NB_CNT-1:0]  r_flush_cnt;

   logic [DEPTH-1:0]   w_next_valid;
   logic [NB_DATA-1:0] w_next_data [DEPTH];
   logic [NB_CTRL-1:0] w_next_ctrl [DEPTH];
   logic [NB_OCC-1:0]  w_next_occupancy;

   logic               w_do_flush;
   logic               w_do_stall;
   logic               w_do_shift;

   // Flush takes priority over stall. A stall is counted only when it actually holds the chain.
   assign w_do_flush = i_step & i_flush;
   assign w_do_stall = i_step & i_stall & ~i_flush;
   assign w_do_shift = i_step & ~i_stall | w_do_flush;

   // Next stage contents. Every stage holds by default. On a shift, stage 0 takes either the input or a bubble whose control is zero.
   always_comb begin
      w_next_valid = r_valid;
      w_next_data  = r_data;
      w_next_ctrl  = r_ctrl;
      if (w_do_shift) begin
         for (int k = 1; k < DEPTH; k++) begin
            w_next_valid[k] = r_valid[k-1];
            w_next_data[k]  = r_data[k-1];
            w_next_ctrl[k]  = r_ctrl[k-1];
         end
         if (w_do_flush) begin
            w_next_valid[0] = 1'b0;
            w_next_data[0]  = i_data;
            w_next_ctrl[0]  = '0;
         end else begin
            w_next_valid[0] = i_valid;
            w_next_data[0]  = i_data;
            w_next_ctrl[0]  = i_valid ? i_ctrl : '0;
         end
      end
   end

   // Occupancy is the popcount of the next valid bits, so the registered value updates on the same edge as the stages.
   always_comb begin
      int cnt;
      cnt = 0;
      for (int k = 0; k < DEPTH; k++) begin
         cnt = cnt + int'(w_next_valid[k]);
      end
      w_next_occupancy = NB_OCC'(cnt);
   end

   // Stage registers. Reset empties the chain. When step is low, the combinational hold path keeps every value unchanged.
   always_ff @(negedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid     <= '0;
         r_occupancy <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
            r_ctrl[k] <= '0;
         end
      end else if (i_step) begin
         r_valid     <= w_next_valid;
         r_data      <= w_next_data;
         r_ctrl      <= w_next_ctrl;
         r_occupancy <= w_next_occupancy;
      end
   end

   // Event counters saturate at all-ones. A clear beats an increment on the same edge. Nothing happens while step is low.
   always_ff @(negedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (i_step) begin
         if (i_clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
         end else begin
            if (w_do_stall && r_stall_cnt != CNT_MAX) begin
               r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
            end
            if (w_do_flush && r_flush_cnt != CNT_MAX) begin
               r_flush_cnt <= r_flush_cnt + NB_CNT'(1);
            end
         end
      end
   end

   // The last stage drives the outputs. Control is already zero for any invalid stage.
   assign o_valid     = r_valid[DEPTH-1];
   assign o_data      = r_data[DEPTH-1];
   assign o_ctrl      = r_ctrl[DEPTH-1];
   assign o_occupancy = r_occupancy;
   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;

endmodule
